char_buffer_writer: RTL and testbench
=====================================

Name: char_buffer_writer

Overview:
Terminal-style front end that turns a byte stream from the CPU into writes on the character buffer's write port.
- Keeps a cursor and a hardware scroll offset.
- Handles control codes, line wrap, scroll with bottom-row blanking, and full-screen clear.
- Exports `top_row` so the video read side can rotate row addressing; scrolling never copies RAM.

Parameters:
- ROWS, 30, text rows on screen.
- COLS_40, 40, columns in 40-col mode.
- COLS_80, 80, columns in 80-col mode.
- ADDR_WIDTH, 12, width of buffer address (must cover ROWS*COLS_80 = 2400).

Ports:
- clk_cpu  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mode_80col  in  1  column mode: 1 = 80 cols, 0 = 40 cols.
- char_valid  in  1  char_data is presented.
- char_data  in  8  byte to display or control code.
- char_ready  out  1  block can accept a byte this cycle.
- clear_req  in  1  single-cycle request for full-screen clear.
- addr_write  out  ADDR_WIDTH  buffer write address.
- data_write  out  8  buffer write data.
- we  out  1  buffer write enable.
- cursor_col  out  7  logical cursor column.
- cursor_row  out  5  logical cursor row, 0 = top visible row.
- top_row  out  5  physical buffer row shown as the top screen row.
- busy  out  1  fill in progress.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0: we=0, addr_write=0, data_write=0x00, cursor 0/0, top_row=0, busy=0.
  - State IDLE; clear_pending=0; mode_q = mode_80col.
  - No automatic clear.
- cols = mode_80col ? COLS_80 : COLS_40.
- Address mapping:
  - phys_row = (top_row + cursor_row) mod ROWS.
  - addr = phys_row*cols + cursor_col.
- Handshake:
  - char_ready = (state==IDLE) && !clear_req && !clear_pending && (mode_80col==mode_q). Combinational.
  - A byte is accepted on a cycle where valid && ready.
  - we/addr_write/data_write are registered: a write appears exactly 1 cycle after acceptance, for 1 cycle.
- Byte handling in IDLE (cursor/top_row update in the same cycle the write is registered):
  - 0x20..0x7E: write char at cursor, then advance col. If col was cols-1, set col=0 and perform NEWLINE.
  - 0x0D (CR): col=0, no write.
  - 0x0A (LF): NEWLINE, col unchanged.
  - 0x08 (BS): if col>0 then col-1, no write. At col 0: no-op.
  - 0x0C (FF): start full CLEAR.
  - Any other byte: consumed, no effect.
- NEWLINE:
  - If row<ROWS-1: row+1.
  - Else:
    - Row stays ROWS-1.
    - top_row = (top_row+1) mod ROWS (29 wraps to 0).
    - Enter FILL_ROW on the physical row that just became bottom, i.e. the old top_row.
- FILL_ROW:
  - busy=1, ready=0.
  - One write of 0x20 per cycle, addresses old_top*cols .. old_top*cols+cols-1, ascending.
  - Exactly cols write cycles, then return to IDLE.
- CLEAR (from 0x0C, clear_req, or mode change):
  - busy=1.
  - Writes 0x20 to addresses 0..ROWS*cols-1 (1200 or 2400 cycles).
  - Sets cursor 0/0 and top_row=0 at entry.
  - Returns to IDLE after the last write.
- clear_req handling:
  - clear_req in IDLE starts CLEAR next cycle; it wins over a simultaneous char_valid, and that byte is not accepted.
  - clear_req during FILL_ROW or CLEAR sets clear_pending. A new CLEAR then starts on return to IDLE; multiple requests collapse to one.
- Mode change: mode_80col != mode_q in IDLE → mode_q = mode_80col, start CLEAR using the new cols. During a fill, the change is handled on return to IDLE.
- Reset mid-fill: fill aborted immediately, we=0, all state at reset values.
- Counters: fill counter ADDR_WIDTH bits; no address ever reaches ROWS*cols.

Optional Feature:
- Macro: CHAR_WRITER_TAB_EN.
- Defined: 0x09 (TAB) sets col = (col|7)+1, no write. If the result ≥ cols, col=0 and NEWLINE.
- Undefined: 0x09 is consumed with no effect, like any other unlisted byte.

Test Plan:
- Reset, 40-col, send 0x41 → one cycle later we=1, addr_write=0, data_write=0x41; cursor_col=1.
- 40-col, send 40×0x42 from 0/0 → last write at addr 39; cursor row=1, col=0; no fill.
- Cursor row 29, top_row 0, 40-col, send 0x0A:
  - top_row=1; busy for exactly 40 cycles writing 0x20 to addr 0..39.
  - Then send 0x43 with col=0 → addr 0 (phys row 0).
- 80-col, pulse clear_req together with char_valid=1/0x44:
  - 0x44 not accepted.
  - 2400 writes of 0x20 to addr 0..2399; cursor 0/0, top_row 0; char_ready high afterwards.
- Col 0, send 0x08 → no write, col 0. Col 5, send 0x08 then 0x0D → col 4 then col 0.
- Toggle mode_80col 0→1 mid-FILL_ROW → row fill completes, then full 2400-write clear. With CHAR_WRITER_TAB_EN, TAB at col 3 → col 8; at col 78 (80-col) → col 0, row+1.

Source files
------------

// File: rtl/char_buffer_writer.sv
// char_buffer_writer
//   Terminal-style front end: turns a CPU byte stream into writes on the
//   character buffer write port. Keeps a cursor plus a hardware scroll
//   offset (top_row); scrolling only blanks the new bottom row, the video
//   side rotates its row addressing by top_row so RAM is never copied.
//
//   Optional feature macro: CHAR_WRITER_TAB_EN (0x09 advances to the next
//   multiple-of-8 column). Without it 0x09 is consumed with no effect.
//
// Ports
//   clk_cpu      in   system clock
//   rst_n        in   asynchronous active-low reset
//   mode_80col   in   1 = 80 columns, 0 = 40 columns
//   char_valid   in   char_data is presented
//   char_data    in   byte to display or control code
//   char_ready   out  byte accepted this cycle when char_valid is high
//   clear_req    in   single-cycle full-screen clear request
//   addr_write   out  buffer write address
//   data_write   out  buffer write data
//   we           out  buffer write enable
//   cursor_col   out  logical cursor column
//   cursor_row   out  logical cursor row (0 = top visible row)
//   top_row      out  physical buffer row shown at the top of the screen
//   busy         out  row blank or full clear in progress
module char_buffer_writer #(
  parameter int ROWS       = 30,
  parameter int COLS_40    = 40,
  parameter int COLS_80    = 80,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_cpu,
  input  logic                  rst_n,
  input  logic                  mode_80col,
  input  logic                  char_valid,
  input  logic [7:0]            char_data,
  output logic                  char_ready,
  input  logic                  clear_req,
  output logic [ADDR_WIDTH-1:0] addr_write,
  output logic [7:0]            data_write,
  output logic                  we,
  output logic [6:0]            cursor_col,
  output logic [4:0]            cursor_row,
  output logic [4:0]            top_row,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, FILL_ROW, CLEAR} state_t;

  state_t                  state, state_nxt;
  logic [6:0]              col_nxt;
  logic [4:0]              row_nxt, top_nxt;
  logic [ADDR_WIDTH-1:0]   fill_addr, fill_addr_nxt;
  logic [ADDR_WIDTH-1:0]   fill_last, fill_last_nxt;
  logic                    clear_pending, clear_pending_nxt;
  logic                    mode_q, mode_q_nxt;
  logic                    we_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [7:0]              data_nxt;
  logic                    do_newline, start_clear;

  logic [6:0]              cols;
  logic [5:0]              row_sum;
  logic [4:0]              phys_row;
  logic [ADDR_WIDTH-1:0]   cur_addr, row_base;
`ifdef CHAR_WRITER_TAB_EN
  logic [6:0]              tab_col;
`endif

  function automatic logic [ADDR_WIDTH-1:0] screen_last(input logic m80);
    return ADDR_WIDTH'(ROWS * (m80 ? COLS_80 : COLS_40) - 1);
  endfunction

  // Geometry always follows mode_q: a mode flip during a fill must not
  // disturb the fill that is already running.
  assign cols     = mode_q ? 7'(COLS_80) : 7'(COLS_40);
  assign row_sum  = {1'b0, top_row} + {1'b0, cursor_row};
  assign phys_row = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];
  assign cur_addr = ADDR_WIDTH'(phys_row) * ADDR_WIDTH'(cols) + ADDR_WIDTH'(cursor_col);
  // Physical row that becomes the bottom row on a scroll is the old top row.
  assign row_base = ADDR_WIDTH'(top_row) * ADDR_WIDTH'(cols);

  assign char_ready = (state == IDLE) && !clear_req && !clear_pending && (mode_80col == mode_q);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt         = state;
    col_nxt           = cursor_col;
    row_nxt           = cursor_row;
    top_nxt           = top_row;
    fill_addr_nxt     = fill_addr;
    fill_last_nxt     = fill_last;
    clear_pending_nxt = clear_pending;
    mode_q_nxt        = mode_q;
    we_nxt            = 1'b0;
    addr_nxt          = addr_write;
    data_nxt          = data_write;
    do_newline        = 1'b0;
    start_clear       = 1'b0;
`ifdef CHAR_WRITER_TAB_EN
    tab_col           = (cursor_col | 7'd7) + 7'd1;
`endif

    case (state)
      IDLE: begin
        // Pending clears and mode changes outrank any presented byte.
        if (clear_req || clear_pending || (mode_80col != mode_q)) begin
          start_clear = 1'b1;
        end else if (char_valid) begin
          if ((char_data >= 8'h20) && (char_data <= 8'h7E)) begin
            we_nxt   = 1'b1;
            addr_nxt = cur_addr;
            data_nxt = char_data;
            if (cursor_col == cols - 7'd1) begin
              col_nxt    = '0;
              do_newline = 1'b1;
            end else begin
              col_nxt = cursor_col + 7'd1;
            end
          end else begin
            case (char_data)
              8'h0D: col_nxt = '0;
              8'h0A: do_newline = 1'b1;
              8'h08: if (cursor_col != '0) col_nxt = cursor_col - 7'd1;
              8'h0C: start_clear = 1'b1;
`ifdef CHAR_WRITER_TAB_EN
              8'h09: begin
                if (tab_col >= cols) begin
                  col_nxt    = '0;
                  do_newline = 1'b1;
                end else begin
                  col_nxt = tab_col;
                end
              end
`endif
              default: ;
            endcase
          end
        end
      end
      default: begin
        // FILL_ROW and CLEAR: one blank per cycle from fill_addr to fill_last.
        we_nxt   = 1'b1;
        addr_nxt = fill_addr;
        data_nxt = 8'h20;
        if (clear_req) clear_pending_nxt = 1'b1;
        if (fill_addr == fill_last) begin
          state_nxt = IDLE;
        end else begin
          fill_addr_nxt = fill_addr + 1'b1;
        end
      end
    endcase

    if (do_newline) begin
      if (cursor_row < 5'(ROWS - 1)) begin
        row_nxt = cursor_row + 5'd1;
      end else begin
        top_nxt       = (top_row == 5'(ROWS - 1)) ? '0 : top_row + 5'd1;
        state_nxt     = FILL_ROW;
        fill_addr_nxt = row_base;
        fill_last_nxt = row_base + ADDR_WIDTH'(cols - 7'd1);
      end
    end

    if (start_clear) begin
      state_nxt         = CLEAR;
      mode_q_nxt        = mode_80col;
      clear_pending_nxt = 1'b0;
      col_nxt           = '0;
      row_nxt           = '0;
      top_nxt           = '0;
      fill_addr_nxt     = '0;
      fill_last_nxt     = screen_last(mode_80col);
    end
  end

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cursor_col    <= '0;
      cursor_row    <= '0;
      top_row       <= '0;
      fill_addr     <= '0;
      fill_last     <= '0;
      clear_pending <= 1'b0;
      mode_q        <= mode_80col;
      we            <= 1'b0;
      addr_write    <= '0;
      data_write    <= '0;
    end else begin
      state         <= state_nxt;
      cursor_col    <= col_nxt;
      cursor_row    <= row_nxt;
      top_row       <= top_nxt;
      fill_addr     <= fill_addr_nxt;
      fill_last     <= fill_last_nxt;
      clear_pending <= clear_pending_nxt;
      mode_q        <= mode_q_nxt;
      we            <= we_nxt;
      addr_write    <= addr_nxt;
      data_write    <= data_nxt;
    end
  end

endmodule

// File: tb/tb_char_buffer_writer.sv
// Testbench for char_buffer_writer: directed scenarios plus random byte
// stream, checked transaction by transaction against a screen-level model
// (cursor, scroll offset and the expected list of buffer writes).
module tb_char_buffer_writer;

  logic        clk_cpu = 1'b0;
  logic        rst_n, mode_80col, char_valid, clear_req;
  logic [7:0]  char_data;
  logic        char_ready, we, busy;
  logic [11:0] addr_write;
  logic [7:0]  data_write;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row, top_row;

  char_buffer_writer #(.ROWS(30), .COLS_40(40), .COLS_80(80), .ADDR_WIDTH(12)) dut (
    .clk_cpu(clk_cpu), .rst_n(rst_n), .mode_80col(mode_80col),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .clear_req(clear_req), .addr_write(addr_write), .data_write(data_write),
    .we(we), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .top_row(top_row), .busy(busy)
  );

  always #5 clk_cpu = ~clk_cpu;

  int checks = 0, failures = 0;

  // Observed side: every write and every busy cycle, sampled at negedge.
  logic [19:0] obs_q[$];
  int          busy_total = 0;
  always @(negedge clk_cpu) begin
    if (rst_n === 1'b1 && we === 1'b1) obs_q.push_back({addr_write, data_write});
    if (busy === 1'b1) busy_total++;
  end

  // Reference model state.
  logic [19:0] exp_q[$];
  int          exp_busy, obs_base, busy_base;
  int          m_col, m_row, m_top;
  logic        m_mode;
  logic        first_we;
  logic [11:0] first_addr;
  logic [7:0]  first_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic int mcols();
    return m_mode ? 80 : 40;
  endfunction

  task automatic model_newline();
    int old;
    if (m_row < 29) m_row++;
    else begin
      old   = m_top;
      m_top = (m_top + 1) % 30;
      for (int i = 0; i < mcols(); i++) exp_q.push_back({12'(old * mcols() + i), 8'h20});
      exp_busy += mcols();
    end
  endtask

  task automatic model_clear(input logic new_mode);
    m_mode = new_mode;
    m_col = 0; m_row = 0; m_top = 0;
    for (int i = 0; i < 30 * mcols(); i++) exp_q.push_back({12'(i), 8'h20});
    exp_busy += 30 * mcols();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int t;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({12'(((m_top + m_row) % 30) * mcols() + m_col), b});
      m_col++;
      if (m_col == mcols()) begin m_col = 0; model_newline(); end
    end else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h0A) model_newline();
    else if (b == 8'h08) begin if (m_col > 0) m_col--; end
    else if (b == 8'h0C) model_clear(m_mode);
`ifdef CHAR_WRITER_TAB_EN
    else if (b == 8'h09) begin
      t = (m_col | 7) + 1;
      if (t >= mcols()) begin m_col = 0; model_newline(); end
      else m_col = t;
    end
`endif
  endtask

  task automatic wait_ready();
    int n = 0;
    while (char_ready !== 1'b1 && n < 6000) begin @(negedge clk_cpu); n++; end
    if (n >= 6000) chk("ready_timeout", 0, 1);
  endtask

  task automatic begin_txn();
    exp_q.delete();
    exp_busy  = 0;
    obs_base  = obs_q.size();
    busy_base = busy_total;
  endtask

  task automatic finish_txn();
    int nobs, lim, idx;
    wait_ready();
    @(negedge clk_cpu);
    nobs = obs_q.size() - obs_base;
    chk("wr_count", nobs, exp_q.size());
    lim = (nobs < exp_q.size()) ? nobs : exp_q.size();
    if (lim > 0) begin
      idx = lim - 1;
      for (int i = 0; i < lim; i++)
        if (obs_q[obs_base + i] !== exp_q[i]) begin idx = i; break; end
      chk("wr_entry", obs_q[obs_base + idx], exp_q[idx]);
    end
    chk("busy_cycles", busy_total - busy_base, exp_busy);
    chk("cursor_col", cursor_col, m_col);
    chk("cursor_row", cursor_row, m_row);
    chk("top_row", top_row, m_top);
  endtask

  // inject: 0 none, 1 flip mode during the fill, 2 two clear_req pulses during the fill
  task automatic send(input logic [7:0] b, input int inject);
    wait_ready();
    begin_txn();
    model_byte(b);
    char_valid = 1'b1; char_data = b;
    @(posedge clk_cpu);
    @(negedge clk_cpu);
    char_valid = 1'b0;
    first_we = we; first_addr = addr_write; first_data = data_write;
    if (inject == 1) begin
      repeat (5) @(negedge clk_cpu);
      mode_80col = ~mode_80col;
      model_clear(mode_80col);
    end else if (inject == 2) begin
      repeat (5) @(negedge clk_cpu);
      clear_req = 1'b1; @(negedge clk_cpu); clear_req = 1'b0; @(negedge clk_cpu);
      clear_req = 1'b1; @(negedge clk_cpu); clear_req = 1'b0;
      model_clear(m_mode);
    end
    finish_txn();
  endtask

  task automatic set_mode(input logic m);
    wait_ready();
    begin_txn();
    mode_80col = m;
    if (m != m_mode) model_clear(m);
    @(negedge clk_cpu);
    finish_txn();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=0 want=1");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    logic [7:0] b;
    rst_n = 1'b0; mode_80col = 1'b0; char_valid = 1'b0; clear_req = 1'b0; char_data = 8'h00;
    repeat (3) @(negedge clk_cpu);
    chk("rst_we", we, 0);
    chk("rst_addr", addr_write, 0);
    chk("rst_data", data_write, 0);
    chk("rst_col", cursor_col, 0);
    chk("rst_row", cursor_row, 0);
    chk("rst_top", top_row, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    m_col = 0; m_row = 0; m_top = 0; m_mode = 1'b0;
    @(negedge clk_cpu);
    chk("rst_no_autoclear", busy, 0);

    // First printable byte: write one cycle after acceptance.
    send(8'h41, 0);
    chk("first_we", first_we, 1);
    chk("first_addr", first_addr, 0);
    chk("first_data", first_data, 8'h41);

    // Full row of 40 chars wraps to the next row without any fill.
    send(8'h0D, 0);
    for (int i = 0; i < 40; i++) send(8'h42, 0);

    // Scroll from the bottom row: blank physical row 0, then write lands there.
    for (int i = 0; i < 28; i++) send(8'h0A, 0);
    send(8'h0A, 0);
    send(8'h43, 0);
    chk("scroll_addr", first_addr, 0);

    // Backspace / carriage return.
    send(8'h0D, 0);
    send(8'h08, 0);
    chk("bs_at_zero", cursor_col, 0);
    for (int i = 0; i < 5; i++) send(8'h61, 0);
    send(8'h08, 0);
    chk("bs_col", cursor_col, 4);
    send(8'h0D, 0);

    // Mode change to 80 columns clears the screen.
    set_mode(1'b1);

    // clear_req beats a simultaneous byte.
    wait_ready();
    begin_txn();
    clear_req = 1'b1; char_valid = 1'b1; char_data = 8'h44;
    #1 chk("ready_under_clr", char_ready, 0);
    model_clear(m_mode);
    @(posedge clk_cpu);
    @(negedge clk_cpu);
    clear_req = 1'b0; char_valid = 1'b0;
    finish_txn();
    chk("ready_after_clr", char_ready, 1);

`ifdef CHAR_WRITER_TAB_EN
    for (int i = 0; i < 3; i++) send(8'h61, 0);
    send(8'h09, 0);
    chk("tab_col8", cursor_col, 8);
    send(8'h0D, 0);
    for (int i = 0; i < 78; i++) send(8'h62, 0);
    send(8'h09, 0);
`endif

    // Mode flip during a row fill: fill completes, then full clear.
    set_mode(1'b0);
    for (int i = 0; i < 29; i++) send(8'h0A, 0);
    send(8'h0A, 1);

    // Repeated clear_req during a fill collapse into one clear.
    for (int i = 0; i < 29; i++) send(8'h0A, 0);
    send(8'h0A, 2);

    // Reset in the middle of a clear.
    wait_ready();
    char_valid = 1'b1; char_data = 8'h0C;
    @(posedge clk_cpu);
    @(negedge clk_cpu);
    char_valid = 1'b0;
    repeat (10) @(negedge clk_cpu);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", addr_write, 0);
    chk("midrst_top", top_row, 0);
    @(negedge clk_cpu);
    rst_n = 1'b1;
    m_col = 0; m_row = 0; m_top = 0; m_mode = mode_80col;
    @(negedge clk_cpu);
    chk("midrst_ready", char_ready, 1);

    // Random byte stream.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) set_mode(~mode_80col);
      r = $urandom_range(0, 99);
      if (r < 60)      b = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 68) b = 8'h0D;
      else if (r < 82) b = 8'h0A;
      else if (r < 90) b = 8'h08;
      else if (r < 91) b = 8'h0C;
      else if (r < 95) b = 8'h09;
      else             b = 8'($urandom_range(0, 255));
      send(b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
